sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Adds:
  - occupancy count
  - programmable almost-full / almost-empty flags
  - read-while-full pass-through (simultaneous read and write when full)
  - one-cycle overflow/underflow error pulses
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between producer and consumer datapath stages in the same clock domain.

Parameters:
- DATA_WIDTH, 32, word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..FIFO_DEPTH).
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..FIFO_DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- Derived, local: AW = $clog2(FIFO_DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- cs  input  1  chip select; when 0, wr_en/rd_en ignored, no state change, no error pulses.
- wr_en  input  1  write request.
- rd_en  input  1  read request (FWFT: pop/acknowledge head word).
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  read data.
- empty  output  1  count == 0.
- full  output  1  count == FIFO_DEPTH.
- almost_empty  output  1  count <= AE_LEVEL.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  AW+1  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset (rst=1 at posedge), takes priority over all requests:
  - wr/rd pointers (AW+1 bits, extra wrap bit) = 0; count = 0; data_out = 0; overflow = underflow = 0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-stream discards all stored words; a pending read returns nothing.
- Flags and count are combinational from registered state, valid in the same cycle as the pointer update.
- rd_acc = cs & rd_en & !empty.
- wr_acc = cs & wr_en & (!full | rd_acc): a write while full is accepted only if a read is accepted the same cycle.
- Write while empty with simultaneous read: read rejected (underflow pulse), write accepted. No bypass in standard mode.
- On wr_acc: mem[wr_ptr[AW-1:0]] <= data_in; wr_ptr += 1.
- On rd_acc: rd_ptr += 1.
- Pointer wrap: natural modulo 2^(AW+1); full when the low AW bits match and the MSBs differ.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - Never exceeds FIFO_DEPTH; never below 0.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] (1-cycle latency).
  - data_out holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr[AW-1:0]] combinationally; the head word is visible whenever !empty.
  - rd_acc advances to the next word.
  - data_out is don't-care while empty; the bench must not check it.
  - A word written into an empty FIFO is visible on data_out the cycle after the write edge.
- overflow <= cs & wr_en & !wr_acc (registered, high exactly one cycle per rejected write).
- underflow <= cs & rd_en & !rd_acc (registered, same rule).
- Rejected requests change no pointer, count or data.
- cs=0: hold all state; overflow/underflow <= 0.

Test Plan:
- Reset, then write 8 words 0x11..0x18 (DEPTH=8) -> count 1..8; almost_full rises at count 6; full=1 after 8th; almost_empty falls at count 3.
- While full, wr_en alone with data 0xFF -> overflow=1 for one cycle; count stays 8; 0xFF never read back.
- While full, simultaneous wr_en (0xAA) and rd_en -> no overflow; count stays 8; reads return 0x11..0x18 then 0xAA (pointer wrap verified).
- Standard mode: drain to empty, then one extra rd_en -> underflow pulse; data_out holds last value 0xAA; count 0; empty=1.
- FWFT=1: write 0x5A into empty FIFO -> data_out=0x5A next cycle with no rd_en; rd_en -> empty=1, count 0.
- Mid-stream: count=5, assert rst with wr_en=rd_en=1 -> next cycle count=0, empty=1, data_out=0, no error pulse; cs=0 with requests -> no change.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bus for sync_fifo_param
// The master side drives requests and write data; the slave side is the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  cs;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cs, wr_en, rd_en, data_in,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  cs, wr_en, rd_en, data_in,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with occupancy, threshold flags and error pulses
// Pointers carry one extra wrap bit so full/empty and count come straight from their difference.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_TH = (AW+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           occ;
  logic                  is_empty;
  logic                  is_full;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  overflow_q;
  logic                  underflow_q;

  assign occ      = wr_ptr - rd_ptr;
  assign is_empty = (wr_ptr == rd_ptr);
  assign is_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A write into a full FIFO is only taken when a read frees the slot in the same cycle.
  assign rd_acc = bus.cs & bus.rd_en & ~is_empty;
  assign wr_acc = bus.cs & bus.wr_en & (~is_full | rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      overflow_q  <= bus.cs & bus.wr_en & ~wr_acc;
      underflow_q <= bus.cs & bus.rd_en & ~rd_acc;
    end
  end

  // Storage is deliberately left unreset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr[AW-1:0]] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem[rd_ptr[AW-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk) begin
        if (rst)         data_q <= '0;
        else if (rd_acc) data_q <= mem[rd_ptr[AW-1:0]];
      end
      assign bus.data_out = data_q;
    end
  endgenerate

  assign bus.count        = occ;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (occ <= AE_TH);
  assign bus.almost_full  = (occ >= AF_TH);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed bench for sync_fifo_param in standard and FWFT modes
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) s_if ();
  sync_fifo_param_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) f_if ();

  sync_fifo_param #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(s_if));
  sync_fifo_param #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .bus(f_if));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_s(input logic c, input logic w, input logic r, input logic [31:0] d);
    s_if.cs = c; s_if.wr_en = w; s_if.rd_en = r; s_if.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic step_f(input logic c, input logic w, input logic r, input logic [31:0] d);
    f_if.cs = c; f_if.wr_en = w; f_if.rd_en = r; f_if.data_in = d;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_rd [8];
    s_if.cs = 0; s_if.wr_en = 0; s_if.rd_en = 0; s_if.data_in = '0;
    f_if.cs = 0; f_if.wr_en = 0; f_if.rd_en = 0; f_if.data_in = '0;

    rst = 1'b1;
    step_s(1, 1, 1, 32'h77);
    chk("rst_count", 32'(s_if.count), 0);
    chk("rst_empty", 32'(s_if.empty), 1);
    chk("rst_full", 32'(s_if.full), 0);
    chk("rst_ae", 32'(s_if.almost_empty), 1);
    chk("rst_af", 32'(s_if.almost_full), 0);
    chk("rst_dout", s_if.data_out, 0);
    chk("rst_ovf", 32'(s_if.overflow), 0);
    chk("rst_udf", 32'(s_if.underflow), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step_s(1, 1, 0, 32'h11 + 32'(i));
      chk("fill_count", 32'(s_if.count), 32'(i + 1));
      chk("fill_af", 32'(s_if.almost_full), 32'((i + 1) >= 6));
      chk("fill_ae", 32'(s_if.almost_empty), 32'((i + 1) <= 2));
      chk("fill_full", 32'(s_if.full), 32'((i + 1) == 8));
    end

    step_s(1, 1, 0, 32'hFF);
    chk("ovf_pulse", 32'(s_if.overflow), 1);
    chk("ovf_count", 32'(s_if.count), 8);
    step_s(1, 0, 0, 32'h0);
    chk("ovf_clear", 32'(s_if.overflow), 0);

    step_s(1, 1, 1, 32'hAA);
    chk("rwf_ovf", 32'(s_if.overflow), 0);
    chk("rwf_count", 32'(s_if.count), 8);
    chk("rwf_full", 32'(s_if.full), 1);
    chk("rwf_dout", s_if.data_out, 32'h11);

    exp_rd = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'hAA};
    for (int i = 0; i < 8; i++) begin
      step_s(1, 0, 1, 32'h0);
      chk("drain_dout", s_if.data_out, exp_rd[i]);
      chk("drain_count", 32'(s_if.count), 32'(7 - i));
    end
    chk("drain_empty", 32'(s_if.empty), 1);

    step_s(1, 0, 1, 32'h0);
    chk("udf_pulse", 32'(s_if.underflow), 1);
    chk("udf_dout_hold", s_if.data_out, 32'hAA);
    chk("udf_count", 32'(s_if.count), 0);
    chk("udf_empty", 32'(s_if.empty), 1);
    step_s(1, 0, 0, 32'h0);
    chk("udf_clear", 32'(s_if.underflow), 0);

    step_s(1, 1, 1, 32'h33);
    chk("wre_udf", 32'(s_if.underflow), 1);
    chk("wre_count", 32'(s_if.count), 1);
    chk("wre_dout", s_if.data_out, 32'hAA);

    for (int i = 0; i < 4; i++) step_s(1, 1, 0, 32'h34 + 32'(i));
    chk("mid_count", 32'(s_if.count), 5);
    rst = 1'b1;
    step_s(1, 1, 1, 32'h55);
    rst = 1'b0;
    chk("mid_rst_count", 32'(s_if.count), 0);
    chk("mid_rst_empty", 32'(s_if.empty), 1);
    chk("mid_rst_dout", s_if.data_out, 0);
    chk("mid_rst_ovf", 32'(s_if.overflow), 0);
    chk("mid_rst_udf", 32'(s_if.underflow), 0);

    step_s(0, 1, 1, 32'h99);
    chk("cs0_count", 32'(s_if.count), 0);
    chk("cs0_udf", 32'(s_if.underflow), 0);
    chk("cs0_ovf", 32'(s_if.overflow), 0);
    step_s(1, 1, 0, 32'h41);
    step_s(0, 0, 1, 32'h0);
    chk("cs0_hold_count", 32'(s_if.count), 1);
    chk("cs0_hold_dout", s_if.data_out, 0);
    step_s(1, 0, 1, 32'h0);
    chk("cs1_read", s_if.data_out, 32'h41);
    step_s(0, 0, 0, 32'h0);

    step_f(1, 1, 0, 32'h5A);
    chk("fwft_dout", f_if.data_out, 32'h5A);
    chk("fwft_count", 32'(f_if.count), 1);
    chk("fwft_empty", 32'(f_if.empty), 0);
    step_f(1, 1, 0, 32'h5B);
    chk("fwft_head_hold", f_if.data_out, 32'h5A);
    chk("fwft_count2", 32'(f_if.count), 2);
    step_f(1, 0, 1, 32'h0);
    chk("fwft_next", f_if.data_out, 32'h5B);
    chk("fwft_count1", 32'(f_if.count), 1);
    step_f(1, 0, 1, 32'h0);
    chk("fwft_empty_after", 32'(f_if.empty), 1);
    chk("fwft_count0", 32'(f_if.count), 0);
    step_f(1, 0, 1, 32'h0);
    chk("fwft_udf", 32'(f_if.underflow), 1);
    step_f(0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
